board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Owns the single-port 48-word game-board color RAM, one word per cell of the 6x8 board.
- Two requesters share that RAM:
  - CPU store traffic decoded off the MIO bus (ram_addr / ram_data_in / data_ram_we).
  - The VGA pixel renderer, which fetches one cell color per request.
- CPU writes are buffered in a small FIFO. The renderer has priority, with a starvation guard for the CPU.
- Also holds the cursor row/column and score registers that the top level currently decodes inline.

Parameters:
- CELLS, 48: number of board cells (6 columns x 8 rows).
- BASE_WORD, 500: CPU word address of cell 0.
- CURX_WORD, 498: CPU word address of the cursor row register.
- CURY_WORD, 497: CPU word address of the cursor column register.
- SCORE_WORD, 12'hCFF: CPU word address of the score register.
- FIFO_DEPTH, 4: CPU write buffer entries (power of 2).
- STARVE_MAX, 8: consecutive VGA grants allowed while the FIFO is non-empty.

Ports:
- clk, in, 1: system clock (clk_100mhz domain).
- RSTN, in, 1: asynchronous active-low reset.
- cpu_we, in, 1: CPU store strobe, one cycle per store.
- cpu_addr, in, 12: CPU word address.
- cpu_wdata, in, 32: CPU store data.
- cpu_ready, out, 1: FIFO not full.
- wr_ovf, out, 1: sticky flag; a board store was dropped.
- vga_req, in, 1: renderer fetch request, held until vga_ack.
- vga_idx, in, 6: cell index, row*6+col.
- vga_ack, out, 1: one-cycle pulse; vga_rdata is valid in the same cycle.
- vga_rdata, out, 32: cell color.
- ram_en, out, 1: RAM access enable.
- ram_we, out, 1: RAM write.
- ram_addr, out, 6: RAM cell index.
- ram_wdata, out, 32: RAM write data.
- ram_rdata, in, 32: RAM read data, valid the cycle after ram_en with ram_we=0.
- cursor_x, out, 3: cursor row.
- cursor_y, out, 3: cursor column.
- score, out, 32: score register.

Behaviour:
- Reset (RSTN low, asynchronous):
  - All outputs 0. cpu_ready=1 once FIFO pointers are clear.
  - FIFO emptied, state IDLE, starvation counter 0, wr_ovf 0.
  - A reset mid-access aborts the access. No ack is issued and no RAM write is committed after reset asserts.
- CPU decode, on cycles with cpu_we=1:
  - cpu_addr==CURX_WORD: cursor_x <= cpu_wdata[2:0] at the next edge.
  - cpu_addr==CURY_WORD: cursor_y <= cpu_wdata[2:0].
  - cpu_addr==SCORE_WORD: score <= cpu_wdata.
  - BASE_WORD <= cpu_addr < BASE_WORD+CELLS: push {cpu_addr-BASE_WORD, cpu_wdata} into the FIFO.
  - If the FIFO is full, the store is dropped and wr_ovf is set (sticky until reset). This holds even if a pop occurs in the same cycle.
  - All other addresses are ignored.
- FIFO behaviour:
  - cpu_ready = !full.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Order is preserved, so repeated stores to one cell commit last-writer-wins.
- State machine (IDLE, RD, RDRET, WR):
  - IDLE, arbitration per cycle:
    - Grant VGA if vga_req=1 and (FIFO empty or starve_cnt < STARVE_MAX).
    - Otherwise grant the CPU if the FIFO is non-empty.
    - Otherwise stay in IDLE.
  - VGA grant with vga_idx < CELLS: drive ram_en=1, ram_we=0, ram_addr=vga_idx; go to RD.
  - VGA grant with vga_idx >= CELLS: no RAM access; go to RDRET with vga_rdata forced to 0.
  - RD: capture ram_rdata into vga_rdata; go to RDRET.
  - RDRET: vga_ack=1 for this cycle only; return to IDLE.
  - VGA latency: request seen in IDLE at cycle N gives ack at cycle N+2.
  - CPU grant: drive ram_en=1, ram_we=1, ram_addr/ram_wdata from the FIFO head; pop; go to WR.
  - WR: one idle turnaround cycle; return to IDLE.
- Starvation counter:
  - Increments on each VGA grant while the FIFO is non-empty.
  - Clears on each CPU grant and whenever the FIFO is empty.
  - Saturates at STARVE_MAX.
- vga_req dropped before ack: the in-flight access completes and is acked anyway; the renderer ignores the stray ack.
- ram_en and ram_we are 0 in every cycle not listed above.

Decomposition:
- Shared package board_pkg holds:
  - the cell-count and address constants (CELLS, BASE_WORD, CURX_WORD, CURY_WORD, SCORE_WORD);
  - the state enum {IDLE, RD, RDRET, WR};
  - the FIFO entry struct {idx[5:0], data[31:0]}.
- Natural sub-module: wr_fifo, a synchronous FIFO with full/empty flags and an async active-low clear. It is used here for the CPU write buffer.

Test Plan:
- Reset scenario: assert RSTN=0 mid-RD -> outputs 0, no vga_ack, no ram_we; after release, cpu_ready=1 and wr_ovf=0.
- CPU board store: CPU store addr 505 data 6, no VGA traffic -> RAM write idx 5 data 6 within 2 cycles; then vga_idx=5 returns vga_rdata=6 with ack exactly 2 cycles after grant.
- Register decode: stores to 498=3, 497=4, 0xCFF=0x1234 -> cursor_x=3, cursor_y=4, score=0x1234. No FIFO push and no RAM activity.
- Overflow: 5 back-to-back board stores while vga_req is held high -> 4 accepted, 5th dropped, wr_ovf=1, cpu_ready=0; all 4 drain in order.
- Starvation guard: continuous vga_req with FIFO non-empty -> exactly one CPU write after every 8 VGA grants.
- Out-of-range index: vga_idx=50 -> ack with vga_rdata=0 and ram_en never asserted.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants and types for the game-board RAM arbiter: CPU address map,
// arbiter states and the CPU write-buffer entry layout.
package board_pkg;

    localparam int          CELLS      = 48;
    localparam logic [11:0] BASE_WORD  = 12'd500;
    localparam logic [11:0] CURX_WORD  = 12'd498;
    localparam logic [11:0] CURY_WORD  = 12'd497;
    localparam logic [11:0] SCORE_WORD = 12'hCFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        RDRET = 2'd2,
        WR    = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Renderer fetch handshake plus the board RAM port; master is the arbiter side,
// slave is the renderer/RAM side.
interface board_ram_arbiter_if;

    logic        vga_req;
    logic [5:0]  vga_idx;
    logic        vga_ack;
    logic [31:0] vga_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        input  vga_req, vga_idx, ram_rdata,
        output vga_ack, vga_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output vga_req, vga_idx, ram_rdata,
        input  vga_ack, vga_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/board_ram_arbiter_wr_fifo.sv
// Synchronous FIFO for buffered CPU board stores; pushes are refused when full
// even if a pop happens in the same cycle.
module wr_fifo
    import board_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t  mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Arbitrates the single-port board color RAM between buffered CPU stores and
// renderer fetches, and holds the cursor and score registers.
module board_ram_arbiter
    import board_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       RSTN,
    input  logic                       cpu_we,
    input  logic [11:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic                       cpu_ready,
    output logic                       wr_ovf,
    board_ram_arbiter_if.master        bus,
    output logic [2:0]                 cursor_x,
    output logic [2:0]                 cursor_y,
    output logic [31:0]                score
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t       state_q, state_d;
    logic [SW-1:0] starve_q;
    logic [31:0]  rdata_q;
    logic         board_hit;
    logic         fifo_full, fifo_empty;
    fifo_entry_t  push_entry, head;
    logic         grant_vga, grant_cpu;
    logic         vga_oor;

    assign board_hit      = cpu_we && (cpu_addr >= BASE_WORD) && (cpu_addr < BASE_WORD + 12'(CELLS));
    assign push_entry.idx  = 6'(cpu_addr - BASE_WORD);
    assign push_entry.data = cpu_wdata;
    assign cpu_ready      = !fifo_full;
    assign vga_oor        = (bus.vga_idx >= 6'(CELLS));

    wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .rst_n (RSTN),
        .push  (board_hit),
        .din   (push_entry),
        .pop   (grant_cpu),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            cursor_x <= '0;
            cursor_y <= '0;
            score    <= '0;
            wr_ovf   <= 1'b0;
        end else if (cpu_we) begin
            if (cpu_addr == CURX_WORD)  cursor_x <= cpu_wdata[2:0];
            if (cpu_addr == CURY_WORD)  cursor_y <= cpu_wdata[2:0];
            if (cpu_addr == SCORE_WORD) score    <= cpu_wdata;
            if (board_hit && fifo_full) wr_ovf   <= 1'b1;
        end
    end

    // Grants are gated by RSTN so nothing reaches the RAM while reset is held.
    always_comb begin
        state_d       = state_q;
        grant_vga     = 1'b0;
        grant_cpu     = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.vga_ack   = 1'b0;
        case (state_q)
            IDLE: begin
                if (RSTN) begin
                    if (bus.vga_req && (fifo_empty || starve_q < SW'(STARVE_MAX))) begin
                        grant_vga = 1'b1;
                        if (!vga_oor) begin
                            bus.ram_en   = 1'b1;
                            bus.ram_addr = bus.vga_idx;
                            state_d      = RD;
                        end else begin
                            state_d = RDRET;
                        end
                    end else if (!fifo_empty) begin
                        grant_cpu     = 1'b1;
                        bus.ram_en    = 1'b1;
                        bus.ram_we    = 1'b1;
                        bus.ram_addr  = head.idx;
                        bus.ram_wdata = head.data;
                        state_d       = WR;
                    end
                end
            end
            RD:      state_d = RDRET;
            RDRET: begin
                bus.vga_ack = 1'b1;
                state_d     = IDLE;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            starve_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_empty || grant_cpu)
                starve_q <= '0;
            else if (grant_vga && starve_q < SW'(STARVE_MAX))
                starve_q <= starve_q + SW'(1);
            if (state_q == RD)
                rdata_q <= bus.ram_rdata;
            else if (grant_vga && vga_oor)
                rdata_q <= '0;
        end
    end

    assign bus.vga_rdata = rdata_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural board RAM and
// scoreboards for RAM writes and renderer fetches.
module tb_board_ram_arbiter;
    import board_pkg::*;

    logic        clk = 1'b0;
    logic        RSTN;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        wr_ovf;
    logic [2:0]  cursor_x;
    logic [2:0]  cursor_y;
    logic [31:0] score;

    board_ram_arbiter_if bus();

    board_ram_arbiter dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .wr_ovf    (wr_ovf),
        .bus       (bus.master),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .score     (score)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    fifo_entry_t wr_q[$];
    logic [31:0] vga_q[$];
    logic [31:0] mem [64];

    bit vga_chk     = 1'b1;
    bit starve_mode = 1'b0;
    int writes_seen = 0;
    int vga_grants  = 0;
    int ram_en_cnt  = 0;
    int ack_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural single-port RAM: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    always @(negedge clk) begin
        fifo_entry_t e;
        if (bus.ram_en) ram_en_cnt++;
        if (bus.ram_en && !bus.ram_we) vga_grants++;
        if (bus.ram_en && bus.ram_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected_ram_write", 32'd1, 32'd0);
            end else begin
                e = wr_q.pop_front();
                check("ram_wr_idx", {26'd0, bus.ram_addr}, {26'd0, e.idx});
                check("ram_wr_data", bus.ram_wdata, e.data);
            end
            if (starve_mode) begin
                if (writes_seen > 0) check("starve_gap", 32'(vga_grants), 32'd8);
                writes_seen++;
            end
            vga_grants = 0;
        end
        if (bus.vga_ack) begin
            ack_cnt++;
            if (vga_chk) begin
                if (vga_q.size() == 0) check("stray_vga_ack", 32'd1, 32'd0);
                else                   check("vga_rdata", bus.vga_rdata, vga_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [11:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic board_store(input logic [5:0] idx, input logic [31:0] d);
        wr_q.push_back('{idx: idx, data: d});
        cpu_store(BASE_WORD + 12'(idx), d);
    endtask

    task automatic vga_fetch(input logic [5:0] idx, input logic [31:0] exp, output int lat);
        bit got = 1'b0;
        bus.vga_idx = idx;
        bus.vga_req = 1'b1;
        vga_q.push_back(exp);
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.vga_ack) got = 1'b1;
            else             lat++;
        end
        if (!got) check("vga_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.vga_req = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int base_cnt;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        RSTN = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus.vga_req = 1'b0; bus.vga_idx = '0; bus.ram_rdata = '0;

        // Power-on reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_en", {31'd0, bus.ram_en}, 32'd0);
        check("rst_vga_ack", {31'd0, bus.vga_ack}, 32'd0);
        check("rst_vga_rdata", bus.vga_rdata, 32'd0);
        check("rst_score", score, 32'd0);
        check("rst_cursor", {26'd0, cursor_x, cursor_y}, 32'd0);
        check("rst_wr_ovf", {31'd0, wr_ovf}, 32'd0);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        @(posedge clk); #1 RSTN = 1'b1;
        tick();

        // Single board store then read back
        board_store(6'd5, 32'd6);
        repeat (2) tick();
        check("store_commit_2cyc", 32'(wr_q.size()), 32'd0);
        vga_fetch(6'd5, 32'd6, lat);
        check("vga_latency", 32'(lat), 32'd2);

        // Register decode, no RAM traffic
        base_cnt = ram_en_cnt;
        cpu_store(CURX_WORD, 32'd3);
        cpu_store(CURY_WORD, 32'd4);
        cpu_store(SCORE_WORD, 32'h1234);
        repeat (3) tick();
        check("cursor_x", {29'd0, cursor_x}, 32'd3);
        check("cursor_y", {29'd0, cursor_y}, 32'd4);
        check("score", score, 32'h1234);
        check("reg_no_ram", 32'(ram_en_cnt - base_cnt), 32'd0);
        check("reg_cpu_ready", {31'd0, cpu_ready}, 32'd1);

        // Out-of-range fetch
        base_cnt = ram_en_cnt;
        vga_fetch(6'd50, 32'd0, lat);
        check("oor_no_ram_en", 32'(ram_en_cnt - base_cnt), 32'd0);

        // Overflow while the renderer hogs the RAM; last writer wins on cell 10
        vga_chk = 1'b0;
        bus.vga_idx = 6'd0;
        bus.vga_req = 1'b1;
        repeat (2) tick();
        board_store(6'd10, 32'hA1);
        board_store(6'd11, 32'hB2);
        board_store(6'd10, 32'hC3);
        board_store(6'd12, 32'hD4);
        cpu_store(BASE_WORD + 12'd13, 32'hE5);
        @(negedge clk);
        check("ovf_flag", {31'd0, wr_ovf}, 32'd1);
        check("ovf_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        @(posedge clk); #1 bus.vga_req = 1'b0;
        n = 0;
        while (wr_q.size() != 0 && n < 100) begin tick(); n++; end
        check("ovf_drained", 32'(wr_q.size()), 32'd0);
        repeat (4) tick();
        vga_chk = 1'b1;
        check("ovf_sticky", {31'd0, wr_ovf}, 32'd1);
        check("ovf_ready_back", {31'd0, cpu_ready}, 32'd1);
        vga_fetch(6'd10, 32'hC3, lat);
        vga_fetch(6'd11, 32'hB2, lat);
        vga_fetch(6'd12, 32'hD4, lat);
        vga_fetch(6'd13, 32'd0, lat);

        // Reset asserted during RD
        bus.vga_idx = 6'd5;
        bus.vga_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.ram_en && !bus.ram_we) && n < 20);
        check("rd_grant_seen", {31'd0, bus.ram_en}, 32'd1);
        base_cnt = ack_cnt;
        @(posedge clk); #1;
        RSTN = 1'b0;
        bus.vga_req = 1'b0;
        @(negedge clk);
        check("midrd_vga_ack", {31'd0, bus.vga_ack}, 32'd0);
        check("midrd_ram_en", {30'd0, bus.ram_en, bus.ram_we}, 32'd0);
        check("midrd_vga_rdata", bus.vga_rdata, 32'd0);
        check("midrd_wr_ovf", {31'd0, wr_ovf}, 32'd0);
        check("midrd_score", score, 32'd0);
        check("midrd_cursor", {26'd0, cursor_x, cursor_y}, 32'd0);
        repeat (2) tick();
        RSTN = 1'b1;
        repeat (4) tick();
        check("midrd_no_ack", 32'(ack_cnt - base_cnt), 32'd0);
        check("midrd_cpu_ready", {31'd0, cpu_ready}, 32'd1);

        // Starvation guard: one CPU write per 8 renderer grants
        vga_chk = 1'b0;
        bus.vga_idx = 6'd3;
        bus.vga_req = 1'b1;
        repeat (2) tick();
        writes_seen = 0;
        starve_mode = 1'b1;
        board_store(6'd20, 32'h20);
        board_store(6'd21, 32'h21);
        board_store(6'd22, 32'h22);
        board_store(6'd23, 32'h23);
        n = 0;
        while (wr_q.size() != 0 && n < 400) begin tick(); n++; end
        check("starve_drained", 32'(wr_q.size()), 32'd0);
        check("starve_writes", 32'(writes_seen), 32'd4);
        starve_mode = 1'b0;
        @(posedge clk); #1 bus.vga_req = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
